// File: rtl/mem_arbiter.sv
// Round-robin arbiter and access sequencer between the CPU and DMA ports of the
// single unified MIPS memory. Each transaction is IDLE -> MEM_LAT x ACCESS -> RESP.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_dma_q, last_dma_d;
  logic              owner_dma_q, owner_dma_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              pick_dma;
  logic              in_access;
  logic              in_resp;

  // DMA wins when alone, or when both request and the CPU went last.
  assign pick_dma = dma_req & (~cpu_req | ~last_dma_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_dma_d  = last_dma_q;
    owner_dma_d = owner_dma_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_req | dma_req) begin
          owner_dma_d = pick_dma;
          last_dma_d  = pick_dma;
          we_d        = pick_dma ? dma_we    : cpu_we;
          addr_d      = pick_dma ? dma_addr  : cpu_addr;
          wdata_d     = pick_dma ? dma_wdata : cpu_wdata;
          cnt_d       = LAT_M1;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (!we_q) begin
            if (owner_dma_q) dma_rdata_d = mem_rdata;
            else             cpu_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      last_dma_q  <= 1'b1;
      owner_dma_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_dma_q  <= last_dma_d;
      owner_dma_q <= owner_dma_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  assign mem_en    = in_access;
  assign mem_we    = in_access & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign grant     = (in_access | in_resp) ? (owner_dma_q ? 2'b10 : 2'b01) : 2'b00;
  assign cpu_ack   = in_resp & ~owner_dma_q;
  assign dma_ack   = in_resp & owner_dma_q;
  // Combinational so the main controller advances on the edge ending the ack cycle.
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign busy      = (state_q != IDLE);
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model and a reference memory.
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata;
  logic [DW-1:0] cpu_rdata, dma_rdata;
  logic          cpu_ack, dma_ack, cpu_stall, mem_en, mem_we, busy;
  logic [1:0]    grant;

  logic [DW-1:0] mem [64];
  logic [DW-1:0] ref_mem [64];
  logic          pl_en = 1'b0;
  logic [5:0]    pl_idx = '0;
  logic [DW-1:0] pl_val = '0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
  );

  // Word-addressed memory slave; preload port lets the bench seed contents.
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_en && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1; cpu_req = 1'b0; dma_req = 1'b0; cpu_we = 1'b0; dma_we = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic preload(input int idx, input logic [DW-1:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx[5:0]; pl_val = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_req = 1'b1; dma_req = 1'b1;
    cpu_we = 1'b1; dma_we = 1'b1;
    cpu_addr = 32'h44; dma_addr = 32'h48; cpu_wdata = 32'hA5A5A5A5; dma_wdata = 32'h5A5A5A5A;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (grant !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_grant: got %b expected 00", grant); end
    tests_run++; if ({mem_en, mem_we} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_mem_en_we: got %b expected 00", {mem_en, mem_we}); end
    tests_run++; if ({cpu_ack, dma_ack} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_acks: got %b expected 00", {cpu_ack, dma_ack}); end
    tests_run++; if (cpu_rdata !== 32'h0 || dma_rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_rdata: got %h/%h expected 0/0", cpu_rdata, dma_rdata); end
    tests_run++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_mem_bus: got %h/%h expected 0/0", mem_addr, mem_wdata); end
    tests_run++; if (cpu_stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_stall_hi: got %b expected 1", cpu_stall); end
    cpu_req = 1'b0;
    #1;
    tests_run++; if (cpu_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stall_lo: got %b expected 0", cpu_stall); end
    dma_req = 1'b0; cpu_we = 1'b0; dma_we = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    preload(0, 32'h8C220004);
    preload(32, 32'hDEADBEEF);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      tests_run++; if (mem_en !== (c <= LAT)) begin tests_failed++; $display("[TB] FAIL read_mem_en cyc%0d: got %b expected %b", c, mem_en, (c <= LAT)); end
      tests_run++; if (cpu_ack !== (c == LAT + 1)) begin tests_failed++; $display("[TB] FAIL read_ack cyc%0d: got %b expected %b", c, cpu_ack, (c == LAT + 1)); end
      tests_run++; if (cpu_stall !== (c != LAT + 1)) begin tests_failed++; $display("[TB] FAIL read_stall cyc%0d: got %b expected %b", c, cpu_stall, (c != LAT + 1)); end
      tests_run++; if (grant !== 2'b01) begin tests_failed++; $display("[TB] FAIL read_grant cyc%0d: got %b expected 01", c, grant); end
    end
    tests_run++; if (cpu_rdata !== 32'h8C220004) begin tests_failed++; $display("[TB] FAIL read_rdata: got %h expected 8c220004", cpu_rdata); end
    cpu_req = 1'b0;
    @(negedge clk);
    tests_run++; if ({cpu_ack, busy} !== 2'b00) begin tests_failed++; $display("[TB] FAIL read_after_ack: got %b expected 00", {cpu_ack, busy}); end
  endtask

  task automatic test_round_robin();
    int n;
    int who [8];
    int when [8];
    do_reset();
    n = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h80;
    for (int c = 1; c <= 4 * (LAT + 2) + 1; c++) begin
      @(negedge clk);
      if (cpu_ack && dma_ack) begin tests_run++; tests_failed++; $display("[TB] FAIL rr_double_ack cyc%0d: got 11 expected one-hot", c); end
      if ((cpu_ack || dma_ack) && n < 8) begin who[n] = dma_ack ? 1 : 0; when[n] = c; n++; end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    tests_run++; if (n != 4) begin tests_failed++; $display("[TB] FAIL rr_ack_count: got %0d expected 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      tests_run++; if (who[i] != (i % 2)) begin tests_failed++; $display("[TB] FAIL rr_owner%0d: got %0d expected %0d", i, who[i], i % 2); end
      tests_run++; if (when[i] != LAT + 1 + i * (LAT + 2)) begin tests_failed++; $display("[TB] FAIL rr_time%0d: got %0d expected %0d", i, when[i], LAT + 1 + i * (LAT + 2)); end
    end
  endtask

  task automatic test_write_then_read();
    bit got;
    do_reset();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'h12345678;
    got = 1'b0;
    for (int c = 0; c < LAT + 4 && !got; c++) begin @(negedge clk); if (dma_ack) got = 1'b1; end
    dma_req = 1'b0; dma_we = 1'b0;
    tests_run++; if (!got) begin tests_failed++; $display("[TB] FAIL wr_dma_ack: got none expected 1"); end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    got = 1'b0;
    for (int c = 0; c < LAT + 4 && !got; c++) begin @(negedge clk); if (cpu_ack) got = 1'b1; end
    cpu_req = 1'b0;
    tests_run++; if (!got) begin tests_failed++; $display("[TB] FAIL wr_cpu_ack: got none expected 1"); end
    tests_run++; if (cpu_rdata !== 32'h12345678) begin tests_failed++; $display("[TB] FAIL wr_cpu_rdata: got %h expected 12345678", cpu_rdata); end
    tests_run++; if (dma_rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL wr_dma_rdata: got %h expected 0", dma_rdata); end
  endtask

  task automatic test_latched_request();
    int acks;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
    @(negedge clk);
    tests_run++; if (mem_addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL latch_addr_first: got %h expected 0", mem_addr); end
    cpu_addr = 32'h80; cpu_req = 1'b0;
    acks = 0;
    for (int c = 0; c < LAT + 4; c++) begin
      @(negedge clk);
      if (mem_en) begin
        tests_run++; if (mem_addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL latch_addr: got %h expected 0", mem_addr); end
      end
      if (cpu_ack) acks++;
    end
    tests_run++; if (acks != 1) begin tests_failed++; $display("[TB] FAIL latch_ack_count: got %0d expected 1", acks); end
    tests_run++; if (cpu_rdata !== 32'h8C220004) begin tests_failed++; $display("[TB] FAIL latch_rdata: got %h expected 8c220004", cpu_rdata); end
  endtask

  task automatic test_reset_abort();
    int acks;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
    @(negedge clk);
    @(negedge clk);
    tests_run++; if ({busy, mem_en} !== 2'b11) begin tests_failed++; $display("[TB] FAIL abort_pre: got %b expected 11", {busy, mem_en}); end
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    tests_run++; if (grant !== 2'b00) begin tests_failed++; $display("[TB] FAIL abort_grant: got %b expected 00", grant); end
    tests_run++; if (cpu_rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL abort_rdata: got %h expected 0", cpu_rdata); end
    rst = 1'b0;
    acks = 0;
    for (int c = 0; c < LAT + 3; c++) begin @(negedge clk); if (cpu_ack || dma_ack) acks++; end
    tests_run++; if (acks != 0) begin tests_failed++; $display("[TB] FAIL abort_no_ack: got %0d expected 0", acks); end
  endtask

  task automatic test_back_to_back();
    int n;
    int who [8];
    int when [8];
    int exp_who [5];
    exp_who = '{1, 1, 1, 0, 1};
    do_reset();
    n = 0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h4;
    for (int c = 1; c <= 5 * (LAT + 2); c++) begin
      @(negedge clk);
      if ((cpu_ack || dma_ack) && n < 8) begin who[n] = dma_ack ? 1 : 0; when[n] = c; n++; end
      if (cpu_ack) cpu_req = 1'b0;
      if (c == 2 * LAT + 5) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8; end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    tests_run++; if (n != 5) begin tests_failed++; $display("[TB] FAIL b2b_ack_count: got %0d expected 5", n); end
    for (int i = 0; i < 5 && i < n; i++) begin
      tests_run++; if (who[i] != exp_who[i]) begin tests_failed++; $display("[TB] FAIL b2b_owner%0d: got %0d expected %0d", i, who[i], exp_who[i]); end
      tests_run++; if (when[i] != LAT + 1 + i * (LAT + 2)) begin tests_failed++; $display("[TB] FAIL b2b_time%0d: got %0d expected %0d", i, when[i], LAT + 1 + i * (LAT + 2)); end
    end
  endtask

  // Transaction-level model: phase counts cycles since grant (0 = no transaction).
  task automatic test_random();
    int phase;
    bit last_dma, own, t_we;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata, t_result;
    logic [DW-1:0] exp_rd [2];
    bit e_en, e_cack, e_dack;
    logic [1:0] e_grant;
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    do_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    phase = 0; last_dma = 1'b1; own = 1'b0; t_we = 1'b0;
    t_addr = '0; t_wdata = '0; t_result = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      e_en   = (phase >= 1 && phase <= LAT);
      e_cack = (phase == LAT + 1) && !own;
      e_dack = (phase == LAT + 1) && own;
      e_grant = (phase == 0) ? 2'b00 : (own ? 2'b10 : 2'b01);
      tests_run++; if (mem_en !== e_en || mem_we !== (e_en && t_we)) begin tests_failed++; $display("[TB] FAIL rnd_mem_en_we c%0d: got %b%b expected %b%b", cyc, mem_en, mem_we, e_en, e_en && t_we); end
      tests_run++; if ({cpu_ack, dma_ack} !== {e_cack, e_dack}) begin tests_failed++; $display("[TB] FAIL rnd_acks c%0d: got %b%b expected %b%b", cyc, cpu_ack, dma_ack, e_cack, e_dack); end
      tests_run++; if (grant !== e_grant) begin tests_failed++; $display("[TB] FAIL rnd_grant c%0d: got %b expected %b", cyc, grant, e_grant); end
      tests_run++; if (busy !== (phase != 0)) begin tests_failed++; $display("[TB] FAIL rnd_busy c%0d: got %b expected %b", cyc, busy, phase != 0); end
      tests_run++; if (cpu_stall !== (cpu_req && !e_cack)) begin tests_failed++; $display("[TB] FAIL rnd_stall c%0d: got %b expected %b", cyc, cpu_stall, cpu_req && !e_cack); end
      tests_run++; if (cpu_rdata !== exp_rd[0]) begin tests_failed++; $display("[TB] FAIL rnd_cpu_rdata c%0d: got %h expected %h", cyc, cpu_rdata, exp_rd[0]); end
      tests_run++; if (dma_rdata !== exp_rd[1]) begin tests_failed++; $display("[TB] FAIL rnd_dma_rdata c%0d: got %h expected %h", cyc, dma_rdata, exp_rd[1]); end
      if (e_en) begin
        tests_run++; if (mem_addr !== t_addr || mem_wdata !== t_wdata) begin tests_failed++; $display("[TB] FAIL rnd_mem_bus c%0d: got %h/%h expected %h/%h", cyc, mem_addr, mem_wdata, t_addr, t_wdata); end
      end
      if (!cpu_req || e_cack) cpu_req = ($urandom_range(0, 2) != 0);
      if (!dma_req || e_dack) dma_req = ($urandom_range(0, 2) != 0);
      cpu_we = $urandom_range(0, 1) == 1; cpu_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00}; cpu_wdata = $urandom;
      dma_we = $urandom_range(0, 1) == 1; dma_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00}; dma_wdata = $urandom;
      if (phase == 0) begin
        if (cpu_req || dma_req) begin
          own = (cpu_req && dma_req) ? !last_dma : dma_req;
          last_dma = own;
          t_we    = own ? dma_we : cpu_we;
          t_addr  = own ? dma_addr : cpu_addr;
          t_wdata = own ? dma_wdata : cpu_wdata;
          t_result = ref_mem[t_addr[7:2]];
          if (t_we) ref_mem[t_addr[7:2]] = t_wdata;
          phase = 1;
        end
      end else if (phase == LAT + 1) begin
        phase = 0;
      end else begin
        phase++;
        if (phase == LAT + 1 && !t_we) exp_rd[own] = t_result;
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  initial begin
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    rst = 1'b1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_then_read();
    test_latched_request();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
